instruction_loader: RTL and testbench
=====================================

# instruction_loader

Program loader that sits directly upstream of the instruction memory's write port. It takes the byte stream delivered by the UART receiver, assembles 32-bit instruction words MSB-first, and writes them to consecutive instruction-memory addresses starting at 0. Loading ends when the HALT word is written or the memory fills. Control comes from the debug unit through a start pulse and done/error/busy status.

## Interface
Parameters:
- NB_DATA, 8: UART byte width.
- MEMORY_WIDTH, 32: instruction word width; must equal 4*NB_DATA.
- MEMORY_DEPTH, 64: instruction memory entries.
- NB_ADDR, 6: write address width; 2**NB_ADDR >= MEMORY_DEPTH.
- HALT_INSTRUCTION, 32'hFFFFFFFF: terminating word.
- TIMEOUT_CYCLES, 2000000: inter-byte timeout. Used only with LOADER_TIMEOUT_EN.

Ports:
- i_clock, input, 1: clock. All logic is on the rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_start, input, 1: one-cycle pulse that starts a load.
- i_rx_data, input, NB_DATA: received byte. Valid when i_rx_done=1.
- i_rx_done, input, 1: one-cycle byte-valid strobe.
- o_write_addr, output, NB_ADDR: connects to the instruction memory's i_write_addr.
- o_write_data, output, MEMORY_WIDTH: connects to i_data.
- o_write_enable, output, 1: connects to i_write_enable. One-cycle strobe.
- o_busy, output, 1: high in RECEIVE or WRITE.
- o_done, output, 1: high in DONE.
- o_error, output, 1: high in ERROR.

## Operation
- Internal registers:
  - state
  - word shift register (MEMORY_WIDTH bits)
  - byte_cnt (2 bits)
  - addr (NB_ADDR bits)
  - timeout counter (only with the macro)
- States:
  - IDLE: all outputs 0. On i_start, go to RECEIVE and set addr=0, byte_cnt=0, word=0.
  - RECEIVE: on i_rx_done, word <= {word[MEMORY_WIDTH-NB_DATA-1:0], i_rx_data} and byte_cnt increments. When the 4th byte is captured (byte_cnt==3 on entry), go to WRITE.
  - WRITE: lasts exactly one cycle. o_write_enable=1, o_write_data=word, o_write_addr=addr. Then:
    - If word==HALT_INSTRUCTION, go to DONE.
    - Else if addr==MEMORY_DEPTH-1, go to ERROR (memory full with no HALT).
    - Else addr increments and the state returns to RECEIVE.
- Byte during WRITE: an i_rx_done arriving in WRITE is captured as byte 1 of the next word (byte_cnt=1), unless the transition is to DONE or ERROR, in which case the byte is dropped.
- DONE and ERROR: status is held. i_start restarts the load exactly as from IDLE. i_rx_done is ignored.
- i_start in RECEIVE or WRITE is ignored.
- Bytes are never dropped in RECEIVE.
- o_write_addr and o_write_data are 0 in every state other than WRITE.

## Timing
- Reset: state=IDLE; all outputs 0; addr=0, byte_cnt=0, word=0. Reset takes precedence over every other input in the same cycle.
- Reset mid-load discards the partial word. No write occurs, and memory contents are not touched.
- Outputs are registered and decoded from state.
- If the 4th i_rx_done of a word is sampled at edge N, o_write_enable is high for the single cycle between edges N and N+1. The instruction memory commits the word at edge N+1.
- o_busy rises the cycle after i_start is sampled.
- After the HALT write, o_done rises the cycle after the write cycle. The same applies to o_error after the overflow write.
- The maximum accepted byte rate is one byte per cycle.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - The timeout counter clears on entry to RECEIVE and on every i_rx_done.
  - It counts every cycle in RECEIVE.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done in that cycle, the state goes to ERROR and no write is issued for the partial word.
- LOADER_TIMEOUT_EN undefined: no counter is instantiated, and RECEIVE waits indefinitely.

## Test plan
- Two-word load: i_start, then bytes 20 01 00 05 FF FF FF FF. Required response:
  - Write of 0x20010005 at addr 0, then 0xFFFFFFFF at addr 1.
  - o_done=1 and o_busy=0 afterwards.
  - Exactly 2 write strobes.
- Overflow: i_start, then 64 words of 0x00000000. Required response:
  - 64 writes at addr 0..63.
  - Then o_error=1.
  - A 65th word's bytes produce no write.
- Reset mid-word: i_start, bytes AA BB, then i_reset for one cycle. Required response:
  - All outputs are 0 and the state is IDLE.
  - After i_start, bytes 11 22 33 44 write 0x11223344 at addr 0.
- Back-to-back bytes: i_rx_done high every cycle for bytes 01..08, then the HALT bytes. Required response:
  - Byte 05 lands in the WRITE cycle of word 0x01020304.
  - Word 0x05060708 is written at addr 1.
  - HALT is written at addr 2.
- Restart and ignore: i_start pulsed during RECEIVE has no effect. From DONE, i_start followed by bytes CA FE BA BE writes 0xCAFEBABE at addr 0.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16): i_start, one byte, then silence. Required response:
  - o_error=1 within 16 cycles of that byte.
  - No write.
  - Without the macro, o_busy stays 1 after 100 cycles.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Purpose: the loader's control, UART-byte and memory-write signals bundled as one port.
// Ports: i_start, i_rx_data and i_rx_done flow into the loader.
//        o_write_addr, o_write_data and o_write_enable go to the instruction memory.
//        o_busy, o_done and o_error report status to the debug unit.
// Modports: slave is the loader side; master is the debug/UART/memory environment.
interface instruction_loader_if #(
  parameter int NB_DATA      = 8,
  parameter int MEMORY_WIDTH = 32,
  parameter int NB_ADDR      = 6
);
  logic                    i_start;
  logic [NB_DATA-1:0]      i_rx_data;
  logic                    i_rx_done;
  logic [NB_ADDR-1:0]      o_write_addr;
  logic [MEMORY_WIDTH-1:0] o_write_data;
  logic                    o_write_enable;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_error;

  modport slave (
    input  i_start, i_rx_data, i_rx_done,
    output o_write_addr, o_write_data, o_write_enable, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_rx_data, i_rx_done,
    input  o_write_addr, o_write_data, o_write_enable, o_busy, o_done, o_error
  );
endinterface

// File: rtl/instruction_loader.sv
// Purpose: assembles UART bytes MSB-first into 32-bit words and writes them to
//   instruction memory from address 0 until the HALT word is written or memory fills.
// Latency: the write strobe is high in the cycle after the 4th byte of a word is sampled.
// Backpressure: none; one byte per cycle is accepted, including a byte that arrives in
//   the write cycle (it becomes byte 1 of the next word).
// Ports: i_clock, i_reset (synchronous, active high), bus (instruction_loader_if.slave).
// Optional feature: LOADER_TIMEOUT_EN adds an inter-byte timeout that aborts to ERROR.
module instruction_loader #(
  parameter int                      NB_DATA          = 8,
  parameter int                      MEMORY_WIDTH     = 32,
  parameter int                      MEMORY_DEPTH     = 64,
  parameter int                      NB_ADDR          = 6,
  parameter logic [MEMORY_WIDTH-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
  parameter int                      TIMEOUT_CYCLES   = 2000000
) (
  input logic                  i_clock,
  input logic                  i_reset,
  instruction_loader_if.slave  bus
);

  // Elaboration-time sanity checks on the parameter set.
  if (MEMORY_WIDTH != 4 * NB_DATA) begin : g_bad_width
    $error("MEMORY_WIDTH must equal 4*NB_DATA");
  end
  if ((2 ** NB_ADDR) < MEMORY_DEPTH) begin : g_bad_addr
    $error("NB_ADDR too narrow for MEMORY_DEPTH");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [MEMORY_WIDTH-1:0] word_q, word_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [NB_ADDR-1:0]      addr_q, addr_d;

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
`ifdef LOADER_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Bytes are ignored here; only a start pulse begins a fresh load.
        if (bus.i_start) begin
          state_d    = S_RECEIVE;
          word_d     = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
`ifdef LOADER_TIMEOUT_EN
          tmo_d      = '0;
`endif
        end
      end
      S_RECEIVE: begin
        if (bus.i_rx_done) begin
          word_d     = {word_q[MEMORY_WIDTH-NB_DATA-1:0], bus.i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
`ifdef LOADER_TIMEOUT_EN
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Partial word is abandoned without a write.
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_WRITE: begin
        byte_cnt_d = '0;
        word_d     = '0;
        if (word_q == HALT_INSTRUCTION) begin
          state_d = S_DONE;
        end else if (addr_q == NB_ADDR'(MEMORY_DEPTH - 1)) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_RECEIVE;
          addr_d  = addr_q + 1'b1;
`ifdef LOADER_TIMEOUT_EN
          tmo_d   = '0;
`endif
          // A byte landing in the write cycle starts the next word.
          if (bus.i_rx_done) begin
            word_d     = {{(MEMORY_WIDTH-NB_DATA){1'b0}}, bus.i_rx_data};
            byte_cnt_d = 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state; address/data are gated to zero outside WRITE.
  assign bus.o_write_enable = (state_q == S_WRITE);
  assign bus.o_write_addr   = (state_q == S_WRITE) ? addr_q : '0;
  assign bus.o_write_data   = (state_q == S_WRITE) ? word_q : '0;
  assign bus.o_busy         = (state_q == S_RECEIVE) || (state_q == S_WRITE);
  assign bus.o_done         = (state_q == S_DONE);
  assign bus.o_error        = (state_q == S_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Purpose: self-checking bench for instruction_loader: a word-level loader model predicts
//   every memory write; a compare process checks each cycle; directed tests pin literals.
// Ports: none (top level); drives the DUT through an instruction_loader_if instance.
module tb_instruction_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic rst;

  instruction_loader_if #(.NB_DATA(8), .MEMORY_WIDTH(32), .NB_ADDR(6)) bus ();

  instruction_loader #(
    .NB_DATA(8), .MEMORY_WIDTH(32), .MEMORY_DEPTH(64), .NB_ADDR(6),
    .HALT_INSTRUCTION(32'hFFFF_FFFF), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: byte stream -> list of (addr, word) writes
  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;
  typedef enum {M_IDLE, M_BUSY, M_DONE, M_ERR} mst_t;

  wr_t         exp_q[$];
  mst_t        m_st = M_IDLE;
  int          m_addr = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = '0;

  task automatic m_start();
    if (m_st != M_BUSY) begin
      m_st = M_BUSY; m_addr = 0; m_cnt = 0; m_word = '0;
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    wr_t w;
    if (m_st == M_BUSY) begin
      m_word = (m_word << 8) | {24'd0, b};
      m_cnt++;
      if (m_cnt == 4) begin
        w.a = 6'(m_addr);
        w.d = m_word;
        exp_q.push_back(w);
        m_cnt = 0;
        if (m_word == HALT) m_st = M_DONE;
        else if (m_addr == 63) m_st = M_ERR;
        else m_addr++;
      end
    end
  endtask

  // ---------------- per-cycle compare
  initial begin
    forever begin
      wr_t w;
      @(negedge clk);
      if (bus.o_write_enable === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", {26'd0, bus.o_write_addr}, 32'hDEAD_BEEF);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", {26'd0, bus.o_write_addr}, {26'd0, w.a});
          chk("write_data", bus.o_write_data, w.d);
        end
      end else begin
        chk("idle_addr_data", {26'd0, bus.o_write_addr} | bus.o_write_data, 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    m_byte(b);
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    m_start();
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_st = M_IDLE;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Sends a word MSB-first with one idle cycle between bytes, but no idle after the
  // last byte so the caller sits in the write cycle on return.
  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) begin
      send_byte(t[i*8 +: 8]);
      if (i != 0) tick();
    end
  endtask

  task automatic chk_status(input string name, input logic b, input logic d, input logic e);
    chk(name, {29'd0, bus.o_busy, bus.o_done, bus.o_error}, {29'd0, b, d, e});
  endtask

  task automatic chk_write(input string name, input logic [5:0] a, input logic [31:0] d);
    chk({name, "_we"}, {31'd0, bus.o_write_enable}, 32'd1);
    chk({name, "_addr"}, {26'd0, bus.o_write_addr}, {26'd0, a});
    chk({name, "_data"}, bus.o_write_data, d);
  endtask

  int base;

  initial begin
    bus.i_start = 1'b0; bus.i_rx_done = 1'b0; bus.i_rx_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    do_reset();

    // Reset state
    chk_status("reset_status", 1'b0, 1'b0, 1'b0);
    chk("reset_we", {31'd0, bus.o_write_enable}, 32'd0);

    // Two-word load
    base = wr_cnt;
    pulse_start();
    chk_status("busy_after_start", 1'b1, 1'b0, 1'b0);
    send_word(32'h2001_0005);
    chk_write("w0", 6'd0, 32'h2001_0005);
    tick();
    send_word(HALT);
    chk_write("halt1", 6'd1, HALT);
    tick();
    chk_status("done_after_halt", 1'b0, 1'b1, 1'b0);
    send_byte(8'h55);        // ignored in DONE
    tick();
    chk("two_word_count", 32'(wr_cnt - base), 32'd2);

    // Overflow: 64 zero words, then a 65th produces nothing
    base = wr_cnt;
    pulse_start();
    for (int k = 0; k < 64; k++) begin
      send_word(32'h0);
      if (k == 63) chk_write("last_slot", 6'd63, 32'h0);
      tick();
    end
    chk_status("error_after_full", 1'b0, 1'b0, 1'b1);
    send_word(32'h0);
    tick();
    chk("overflow_count", 32'(wr_cnt - base), 32'd64);
    chk_status("error_held", 1'b0, 1'b0, 1'b1);

    // Reset mid-word
    base = wr_cnt;
    pulse_start();
    send_byte(8'hAA); tick();
    send_byte(8'hBB); tick();
    do_reset();
    chk_status("midreset_status", 1'b0, 1'b0, 1'b0);
    chk("midreset_we", {31'd0, bus.o_write_enable}, 32'd0);
    pulse_start();
    send_word(32'h1122_3344);
    chk_write("after_reset", 6'd0, 32'h1122_3344);
    tick();
    send_word(HALT);
    tick();
    chk("midreset_count", 32'(wr_cnt - base), 32'd2);

    // Back-to-back bytes 01..08 then HALT, one per cycle
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) chk_write("b2b_w0_during_05", 6'd0, 32'h0102_0304);
      send_byte(8'(k));
    end
    chk_write("b2b_w1", 6'd1, 32'h0506_0708);
    for (int k = 0; k < 4; k++) send_byte(8'hFF);
    chk_write("b2b_halt", 6'd2, HALT);
    tick();
    chk_status("b2b_done", 1'b0, 1'b1, 1'b0);

    // Restart from DONE; a start pulse mid-word is ignored
    pulse_start();
    send_byte(8'hCA); tick();
    send_byte(8'hFE); tick();
    pulse_start();
    send_byte(8'hBA); tick();
    send_byte(8'hBE);
    chk_write("restart", 6'd0, 32'hCAFE_BABE);
    tick();
    send_word(HALT);
    chk_write("restart_halt", 6'd1, HALT);
    tick();

    // Inter-byte timeout
    base = wr_cnt;
    pulse_start();
    send_byte(8'h12);
`ifdef LOADER_TIMEOUT_EN
    repeat (16) tick();
    m_st = M_ERR;
    chk_status("timeout_error", 1'b0, 1'b0, 1'b1);
`else
    repeat (100) tick();
    chk_status("no_timeout_busy", 1'b1, 1'b0, 1'b0);
`endif
    chk("timeout_no_write", 32'(wr_cnt - base), 32'd0);
    do_reset();

    tick();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
